nco_phase_corrector: RTL and testbench
======================================

# nco_phase_corrector

Multi-channel, runtime-programmable NCO phase-increment corrector. For each request it computes `phase_inc_corr = phase_inc + floor(phase_inc * coef / 2^CORR_SHIFT)` modulo 2^PHASE_W, using a signed per-channel coefficient held in an internal register file. The product is formed by a serial shift-add engine, so no DSP multiplier is used. The block sits between the frequency-setting logic and the NCO phase accumulators, and trims each channel's reference-clock error at run time.

## Interface
- `PHASE_W`, 32: phase-increment width, unsigned.
- `CORR_W`, 24: coefficient width, signed two's complement.
- `CORR_SHIFT`, 36: coefficient LSB weight is 2^-CORR_SHIFT.
- `NCH`, 2: number of channels. Channel index width is `CH_W = max(1, clog2(NCH))`.
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `coef_we` input 1: coefficient write strobe.
- `coef_ch` input CH_W: channel to write.
- `coef_data` input CORR_W: signed coefficient.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request.
- `in_ch` input CH_W: request channel.
- `phase_inc` input PHASE_W: uncorrected increment.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_ch` output CH_W: channel of the result.
- `phase_inc_corr` output PHASE_W: corrected increment.

## Operation
- **Reset (async, RST_N=0).**
  - State goes to IDLE; all coefficients clear to 0.
  - Outputs: `in_ready`=0, `out_valid`=0, `out_ch`=0, `phase_inc_corr`=0.
  - `in_ready` rises on the first CLK edge after reset is released.
- **Coefficient writes.**
  - A write takes effect at the CLK edge where `coef_we`=1.
  - `coef_ch` >= NCH: the write is ignored.
  - Writes are accepted in any state.
- **Request accept.** Occurs when `in_valid` && `in_ready`. At that edge the block latches `phase_inc`, `in_ch` and `coef[in_ch]`.
  - A write to the same channel on the accept edge is not seen by this request; the old value is used.
  - A later write never alters a computation already in flight.
  - `in_ch` >= NCH: the coefficient used is 0.
- **State machine.**
  - IDLE: `in_ready`=1. On accept, go to MULT with bit counter = 0.
  - MULT: one coefficient bit per cycle, LSB first. Bit k adds `phase_inc << k` to a (PHASE_W+CORR_W)-bit signed accumulator. Bit CORR_W-1 subtracts instead (sign weight). After CORR_W cycles, go to ADD.
  - ADD: `corr = acc >>> CORR_SHIFT` (arithmetic shift, i.e. floor, round toward -inf). Then `phase_inc_corr = phase_inc + corr[PHASE_W-1:0]`, wrapping modulo 2^PHASE_W with no saturation. Register the result and `out_ch`, then go to DONE.
  - DONE: `out_valid`=1. `phase_inc_corr` and `out_ch` stay stable until `out_ready`=1, then go to IDLE.
- **Output hold.** `phase_inc_corr` keeps its last value after the handshake and in IDLE.
- **Sign handling.** `phase_inc` is treated as unsigned: it is zero-extended before the multiply.
- **Reset mid-operation.** The in-flight result is discarded, no `out_valid` pulse occurs, and coefficients clear.

## Timing
- Accept at edge t gives `out_valid`=1 after edge t+CORR_W+1.
- Latency is CORR_W+1 cycles; 25 with the defaults.
- `in_ready` falls after the accept edge and rises one edge after the DONE handshake.
- Minimum request period is CORR_W+3 cycles, when `out_ready` is held at 1.
- `in_ready` must not depend combinationally on `in_valid`.
- `out_valid` must not depend combinationally on `out_ready`.

## Structure
- **Package `nco_corr_pkg`:**
  - state enum {IDLE, MULT, ADD, DONE};
  - default constants for PHASE_W, CORR_W and CORR_SHIFT;
  - the `CH_W` function.
- **Sub-module `serial_shift_add_mult`:**
  - parameters PHASE_W and CORR_W;
  - `start` and `done` handshake;
  - holds the accumulator and bit counter;
  - the sign-bit subtract is inside it.
- **Top level:** coefficient register file, FSM, final add and output registers.

## Test plan
- **NCO trim.** Write `coef[0]`=-480080, then request ch0 with `phase_inc`=858993459. Required: `phase_inc_corr`=858987458 (correction -6001), `out_ch`=0, and `out_valid` exactly 25 cycles after accept.
- **Wrap.** Write `coef[1]`=8388607 (2^23-1), then request ch1 with `phase_inc`=0xFFFFFFFF. Required: `phase_inc_corr`=0x0007FFFE (correction 524287).
- **Floor rounding.** Write `coef[0]`=-8388608, then request with `phase_inc`=0x100. Required: `phase_inc_corr`=0xFF (-1/32 floors to -1). With `coef[0]`=0, the result is 0x100 unchanged.
- **Backpressure and coefficient race.**
  - Hold `out_ready`=0 for 10 cycles in DONE. Required: `out_valid` and data stay stable, and `in_ready`=0 throughout.
  - Write `coef[0]` on the accept edge. Required: the result uses the old coefficient, and the next request uses the new one.
- **Reset mid-operation.** Assert `RST_N`=0 during MULT. Required: immediately `in_ready`=0, `out_valid`=0 and `phase_inc_corr`=0; after release no spurious `out_valid`; a ch0 request then returns `phase_inc` unchanged because the coefficients cleared.

Source files
------------

// File: rtl/nco_corr_pkg.sv
// Shared types and defaults for the NCO phase-increment corrector.
package nco_corr_pkg;

    typedef enum logic [1:0] {IDLE, MULT, ADD, DONE} state_e;

    localparam int PHASE_W_DEF    = 32;
    localparam int CORR_W_DEF     = 24;
    localparam int CORR_SHIFT_DEF = 36;
    localparam int NCH_DEF        = 2;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_shift_add_mult.sv
// Serial signed-by-unsigned multiplier: one multiplier bit per cycle, LSB first,
// with the top bit carrying negative weight (two's complement).
module serial_shift_add_mult #(
    parameter  int PHASE_W = 32,
    parameter  int CORR_W  = 24,
    localparam int ACC_W   = PHASE_W + CORR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [PHASE_W-1:0]       mcand_i,
    input  logic signed [CORR_W-1:0] mplier_i,
    output logic                     done_o,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int CNT_W = (CORR_W <= 1) ? 1 : $clog2(CORR_W);

    logic [ACC_W-1:0]        mcand_q;
    logic [CORR_W-1:0]       mplier_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q;
    logic                    last;

    assign last   = busy_q && (cnt_q == CNT_W'(CORR_W - 1));
    assign done_o = last;
    assign acc_o  = acc_q;

    // mcand is pre-shifted each cycle so bit k adds (mcand << k) without a barrel shifter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= ACC_W'(mcand_i);
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0])
                acc_q <= last ? acc_q - $signed(mcand_q) : acc_q + $signed(mcand_q);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/nco_phase_corrector.sv
// Per-channel NCO phase-increment trim: out = in + floor(in * coef / 2^CORR_SHIFT) mod 2^PHASE_W.
module nco_phase_corrector
    import nco_corr_pkg::*;
#(
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int CORR_W     = CORR_W_DEF,
    parameter int CORR_SHIFT = CORR_SHIFT_DEF,
    parameter int NCH        = NCH_DEF,
    parameter int CH_W       = ch_w(NCH)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     coef_we,
    input  logic [CH_W-1:0]          coef_ch,
    input  logic signed [CORR_W-1:0] coef_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic [PHASE_W-1:0]       phase_inc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [PHASE_W-1:0]       phase_inc_corr
);

    localparam int ACC_W = PHASE_W + CORR_W;

    state_e                  state_q, state_d;
    logic                    live_q;
    logic signed [CORR_W-1:0] coef_q [NCH];
    logic signed [CORR_W-1:0] coef_sel;
    logic [PHASE_W-1:0]      phase_q, res_q, res_d;
    logic [CH_W-1:0]         ch_q, out_ch_q;
    logic                    accept, mult_done;
    logic signed [ACC_W-1:0] acc, corr_full;

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready       = live_q && (state_q == IDLE);
    assign accept         = in_valid && in_ready;
    assign out_valid      = (state_q == DONE);
    assign out_ch         = out_ch_q;
    assign phase_inc_corr = res_q;

    always_comb begin
        coef_sel = '0;
        if (32'(in_ch) < NCH)
            coef_sel = coef_q[in_ch];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NCH; i++)
                coef_q[i] <= '0;
        end else if (coef_we && (32'(coef_ch) < NCH)) begin
            coef_q[coef_ch] <= coef_data;
        end
    end

    serial_shift_add_mult #(
        .PHASE_W (PHASE_W),
        .CORR_W  (CORR_W)
    ) u_mult (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .start_i  (accept),
        .mcand_i  (phase_inc),
        .mplier_i (coef_sel),
        .done_o   (mult_done),
        .acc_o    (acc)
    );

    // arithmetic shift floors toward -inf; only the low PHASE_W bits matter after wrap
    assign corr_full = acc >>> CORR_SHIFT;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (accept)    state_d = MULT;
            MULT: if (mult_done) state_d = ADD;
            ADD: begin
                res_d   = phase_q + corr_full[PHASE_W-1:0];
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            phase_q  <= '0;
            ch_q     <= '0;
            res_q    <= '0;
            out_ch_q <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            res_q   <= res_d;
            if (accept) begin
                phase_q <= phase_inc;
                ch_q    <= in_ch;
            end
            if (state_q == ADD)
                out_ch_q <= ch_q;
        end
    end

endmodule

// File: tb/tb_nco_phase_corrector.sv
// Randomized + directed bench for nco_phase_corrector against an arithmetic reference model.
module tb_nco_phase_corrector;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               coef_we;
    logic [0:0]         coef_ch;
    logic signed [23:0] coef_data;
    logic               in_valid;
    logic               in_ready;
    logic [0:0]         in_ch;
    logic [31:0]        phase_inc;
    logic               out_valid;
    logic               out_ready;
    logic [0:0]         out_ch;
    logic [31:0]        phase_inc_corr;

    int total = 0;
    int bad   = 0;
    logic signed [23:0] mdl_coef [2];

    always #5 CLK = ~CLK;

    nco_phase_corrector dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .coef_we        (coef_we),
        .coef_ch        (coef_ch),
        .coef_data      (coef_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ch          (in_ch),
        .phase_inc      (phase_inc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ch         (out_ch),
        .phase_inc_corr (phase_inc_corr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact 64-bit product, floor divide by 2^36, wrap to 32 bits
    function automatic logic [31:0] mdl(input logic [31:0] ph, input logic signed [23:0] c);
        longint p, corr;
        p    = longint'({32'd0, ph}) * longint'(c);
        corr = p >>> 36;
        return ph + corr[31:0];
    endfunction

    task automatic wr_coef(input logic [0:0] ch, input logic signed [23:0] val);
        coef_we = 1'b1; coef_ch = ch; coef_data = val;
        @(negedge CLK);
        coef_we = 1'b0;
        mdl_coef[ch] = val;
    endtask

    task automatic run_req(input logic [0:0] ch, input logic [31:0] ph, input int hold,
                           input bit race, input logic signed [23:0] race_val,
                           output logic [31:0] got);
        logic signed [23:0] c;
        logic [31:0] exp;
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge CLK); n++; end
        check("ready_wait", in_ready, 1);
        c   = mdl_coef[ch];
        exp = mdl(ph, c);
        in_valid = 1'b1; in_ch = ch; phase_inc = ph;
        if (race) begin coef_we = 1'b1; coef_ch = ch; coef_data = race_val; end
        @(negedge CLK);
        in_valid = 1'b0; coef_we = 1'b0;
        if (race) mdl_coef[ch] = race_val;
        check("busy_rdy", in_ready, 0);
        n = 0;
        while (!out_valid && n < 60) begin @(negedge CLK); n++; end
        check("latency", n, 25);
        check("out_ch", out_ch, ch);
        check("result", phase_inc_corr, exp);
        got = phase_inc_corr;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check("hold_vld", out_valid, 1);
            check("hold_data", phase_inc_corr, exp);
            check("hold_ch", out_ch, ch);
            check("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check("drain_vld", out_valid, 0);
        check("rdy_back", in_ready, 1);
        check("out_keep", phase_inc_corr, exp);
    endtask

    initial begin
        logic [31:0] got;
        int n;
        bit seen;
        RST_N = 1'b0; coef_we = 1'b0; coef_ch = '0; coef_data = '0;
        in_valid = 1'b0; in_ch = '0; phase_inc = '0; out_ready = 1'b0;
        mdl_coef[0] = '0; mdl_coef[1] = '0;
        repeat (3) @(negedge CLK);
        check("rst_rdy", in_ready, 0);
        check("rst_vld", out_valid, 0);
        check("rst_ch", out_ch, 0);
        check("rst_data", phase_inc_corr, 0);
        RST_N = 1'b1;
        #1 check("rel_rdy0", in_ready, 0);
        @(negedge CLK);
        check("rel_rdy1", in_ready, 1);

        // NCO trim
        wr_coef(0, -24'sd480080);
        run_req(0, 32'd858993459, 0, 0, '0, got);
        check("trim", got, 32'd858987458);

        // wrap
        wr_coef(1, 24'sd8388607);
        run_req(1, 32'hFFFF_FFFF, 0, 0, '0, got);
        check("wrap", got, 32'h0007_FFFE);

        // floor rounding + backpressure + race on accept edge
        wr_coef(0, -24'sd8388608);
        run_req(0, 32'h100, 10, 1, 24'sd0, got);
        check("floor_old", got, 32'hFF);
        run_req(0, 32'h100, 0, 0, '0, got);
        check("race_new", got, 32'h100);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr_coef(1'($urandom_range(0, 1)), 24'($urandom));
            run_req(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                    bit'($urandom_range(0, 1)), 24'($urandom), got);
        end

        // reset mid-operation
        wr_coef(0, 24'sd12345);
        n = 0;
        while (!in_ready && n < 100) begin @(negedge CLK); n++; end
        in_valid = 1'b1; in_ch = 1'b0; phase_inc = 32'hDEAD_BEEF;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("mid_rdy", in_ready, 0);
        check("mid_vld", out_valid, 0);
        check("mid_data", phase_inc_corr, 0);
        mdl_coef[0] = '0; mdl_coef[1] = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (out_valid) seen = 1'b1;
        end
        check("no_spurious", seen, 0);
        run_req(0, 32'h1234_5678, 0, 0, '0, got);
        check("rst_clear", got, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
